// File: rtl/bp_common_cfg_link_pkg.sv
// Shared config-link definitions: register map, loader state encoding and write packet.
package bp_common_cfg_link_pkg;

   localparam int unsigned cfg_pkt_addr_width_gp = 16;
   localparam int unsigned cfg_pkt_data_width_gp = 32;

   localparam logic [15:0] cfg_reg_freeze_gp      = 16'h0002;
   localparam logic [15:0] cfg_reg_core_id_gp     = 16'h0003;
   localparam logic [15:0] cfg_reg_icache_mode_gp = 16'h0022;
   localparam logic [15:0] cfg_reg_start_pc_gp    = 16'h0040;
   localparam logic [15:0] cfg_reg_dcache_mode_gp = 16'h0042;
   localparam logic [15:0] cfg_reg_cce_id_gp      = 16'h0060;
   localparam logic [15:0] cfg_reg_cce_mode_gp    = 16'h0061;
   localparam logic [15:0] cfg_reg_ucode_base_gp  = 16'h8000;

   typedef enum logic [3:0] {
      StIdle,
      StFreeze,
      StCoreId,
      StIcacheMode,
      StDcacheMode,
      StCceId,
      StCceUncached,
      StStartPc,
      StUcRd,
      StUcLatch,
      StUcWr,
      StCceMode,
      StUnfreeze,
      StDone
   } bp_cfg_loader_state_e;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
   } bp_cfg_link_pkt_s;

endpackage

// File: rtl/bp_cfg_link_loader.sv
// Config-link initiator: after start, issues the fixed write sequence that brings a tile out of
// reset, including streaming CCE microcode from an external ROM.
module bp_cfg_link_loader
   import bp_common_cfg_link_pkg::*;
#(
   parameter int unsigned cfg_addr_width_p = 16,
   parameter int unsigned cfg_data_width_p = 32,
   parameter int unsigned ucode_depth_p    = 256,
   localparam int unsigned cnt_width_lp     = $clog2(ucode_depth_p + 1),
   localparam int unsigned rom_addr_width_lp = $clog2(ucode_depth_p)
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   input  logic                         start_i,
   input  logic [cfg_data_width_p-1:0]  core_id_i,
   input  logic [cfg_data_width_p-1:0]  icache_mode_i,
   input  logic [cfg_data_width_p-1:0]  dcache_mode_i,
   input  logic [cfg_data_width_p-1:0]  cce_id_i,
   input  logic [cfg_data_width_p-1:0]  cce_mode_i,
   input  logic [cfg_data_width_p-1:0]  start_pc_i,
   input  logic [cnt_width_lp-1:0]      ucode_count_i,
   output logic                         ucode_v_o,
   output logic [rom_addr_width_lp-1:0] ucode_addr_o,
   input  logic [cfg_data_width_p-1:0]  ucode_data_i,
   output logic                         cfg_v_o,
   output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
   output logic [cfg_data_width_p-1:0]  cfg_data_o,
   input  logic                         cfg_ready_i,
   output logic                         busy_o,
   output logic                         done_o
);

   localparam logic [cnt_width_lp-1:0] depth_lp = cnt_width_lp'(ucode_depth_p);

   bp_cfg_loader_state_e state_q, state_d;
   logic [cnt_width_lp-1:0] k_q, k_d;
   logic [cnt_width_lp-1:0] count_q;
   logic [cfg_data_width_p-1:0] core_id_q, icache_mode_q, dcache_mode_q;
   logic [cfg_data_width_p-1:0] cce_id_q, cce_mode_q, start_pc_q, ucode_q;
   bp_cfg_link_pkt_s pkt;
   logic cfg_v, accept, start_accept;

   assign start_accept = start_i & ((state_q == StIdle) | (state_q == StDone));

   always_comb begin
      pkt   = '0;
      cfg_v = 1'b1;
      case (state_q)
         StFreeze:      pkt = '{addr: cfg_reg_freeze_gp,      data: 32'd1};
         StCoreId:      pkt = '{addr: cfg_reg_core_id_gp,     data: 32'(core_id_q)};
         StIcacheMode:  pkt = '{addr: cfg_reg_icache_mode_gp, data: 32'(icache_mode_q)};
         StDcacheMode:  pkt = '{addr: cfg_reg_dcache_mode_gp, data: 32'(dcache_mode_q)};
         StCceId:       pkt = '{addr: cfg_reg_cce_id_gp,      data: 32'(cce_id_q)};
         StCceUncached: pkt = '{addr: cfg_reg_cce_mode_gp,    data: 32'd0};
         StStartPc:     pkt = '{addr: cfg_reg_start_pc_gp,    data: 32'(start_pc_q)};
         StUcWr:        pkt = '{addr: cfg_reg_ucode_base_gp | 16'(k_q), data: 32'(ucode_q)};
         StCceMode:     pkt = '{addr: cfg_reg_cce_mode_gp,    data: 32'(cce_mode_q)};
         StUnfreeze:    pkt = '{addr: cfg_reg_freeze_gp,      data: 32'd0};
         default:       cfg_v = 1'b0;
      endcase
   end

   assign accept = cfg_v & cfg_ready_i;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      case (state_q)
         StIdle, StDone: if (start_i) begin
            state_d = StFreeze;
            k_d     = '0;
         end
         StFreeze:      if (accept) state_d = StCoreId;
         StCoreId:      if (accept) state_d = StIcacheMode;
         StIcacheMode:  if (accept) state_d = StDcacheMode;
         StDcacheMode:  if (accept) state_d = StCceId;
         StCceId:       if (accept) state_d = StCceUncached;
         StCceUncached: if (accept) state_d = StStartPc;
         StStartPc: if (accept) begin
            state_d = (count_q == '0) ? StCceMode : StUcRd;
            k_d     = '0;
         end
         StUcRd:    state_d = StUcLatch;
         StUcLatch: state_d = StUcWr;
         StUcWr: if (accept) begin
            if (k_q == count_q - cnt_width_lp'(1)) begin
               state_d = StCceMode;
            end else begin
               state_d = StUcRd;
               k_d     = k_q + cnt_width_lp'(1);
            end
         end
         StCceMode:  if (accept) state_d = StUnfreeze;
         StUnfreeze: if (accept) state_d = StDone;
         default:    state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q       <= StIdle;
         k_q           <= '0;
         count_q       <= '0;
         core_id_q     <= '0;
         icache_mode_q <= '0;
         dcache_mode_q <= '0;
         cce_id_q      <= '0;
         cce_mode_q    <= '0;
         start_pc_q    <= '0;
         ucode_q       <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         if (start_accept) begin
            // Oversized counts are clamped so the index never leaves the ROM.
            count_q       <= (ucode_count_i > depth_lp) ? depth_lp : ucode_count_i;
            core_id_q     <= core_id_i;
            icache_mode_q <= icache_mode_i;
            dcache_mode_q <= dcache_mode_i;
            cce_id_q      <= cce_id_i;
            cce_mode_q    <= cce_mode_i;
            start_pc_q    <= start_pc_i;
         end
         if (state_q == StUcLatch) ucode_q <= ucode_data_i;
      end
   end

   assign cfg_v_o      = cfg_v;
   assign cfg_addr_o   = cfg_addr_width_p'(pkt.addr);
   assign cfg_data_o   = cfg_data_width_p'(pkt.data);
   assign ucode_v_o    = (state_q == StUcRd);
   assign ucode_addr_o = (state_q == StUcRd) ? k_q[rom_addr_width_lp-1:0] : '0;
   assign busy_o       = (state_q != StIdle) && (state_q != StDone);
   assign done_o       = (state_q == StDone);

endmodule

// File: tb/tb_bp_cfg_link_loader.sv
// Scoreboard bench for bp_cfg_link_loader: expected cfg writes are queued at start and popped on
// each accepted write; a small ROM model answers ucode reads one cycle after the strobe.
module tb_bp_cfg_link_loader;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [31:0] core_id, icache_mode, dcache_mode, cce_id, cce_mode, start_pc;
   logic [8:0]  ucode_count;
   logic        ucode_v;
   logic [7:0]  ucode_addr;
   logic [31:0] ucode_data;
   logic        cfg_v;
   logic [15:0] cfg_addr;
   logic [31:0] cfg_data;
   logic        cfg_ready;
   logic        busy, done;

   logic [31:0] rom [256];
   logic [47:0] sb [$];
   int          n_vec, n_err;
   int          uc_pulses;
   logic [15:0] last_uc_addr;
   bit          rand_ready;
   bit          prev_stall;
   logic [47:0] prev_pkt;

   bp_cfg_link_loader dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .start_i       (start),
      .core_id_i     (core_id),
      .icache_mode_i (icache_mode),
      .dcache_mode_i (dcache_mode),
      .cce_id_i      (cce_id),
      .cce_mode_i    (cce_mode),
      .start_pc_i    (start_pc),
      .ucode_count_i (ucode_count),
      .ucode_v_o     (ucode_v),
      .ucode_addr_o  (ucode_addr),
      .ucode_data_i  (ucode_data),
      .cfg_v_o       (cfg_v),
      .cfg_addr_o    (cfg_addr),
      .cfg_data_o    (cfg_data),
      .cfg_ready_i   (cfg_ready),
      .busy_o        (busy),
      .done_o        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM answers one cycle after the read strobe.
   always @(posedge clk) if (ucode_v) ucode_data <= rom[ucode_addr];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      cfg_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: accepted writes against the scoreboard, plus hold-stability under backpressure.
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check_eq("hold_v", 64'(cfg_v), 64'd1);
            check_eq("hold_pkt", 64'({cfg_addr, cfg_data}), 64'(prev_pkt));
         end
         if (ucode_v) uc_pulses++;
         if (cfg_v && cfg_ready) begin
            if (sb.size() == 0) begin
               check_eq("sb_nonempty", 64'(sb.size()), 64'd1);
            end else begin
               check_eq($sformatf("wr_%04h", cfg_addr), 64'({cfg_addr, cfg_data}),
                        64'(sb.pop_front()));
            end
            if (cfg_addr[15]) last_uc_addr = cfg_addr;
         end
         prev_stall = cfg_v && !cfg_ready;
         prev_pkt   = {cfg_addr, cfg_data};
      end
   end

   task automatic randomize_inputs(input logic [8:0] cnt);
      core_id     = $urandom;
      icache_mode = $urandom;
      dcache_mode = $urandom;
      cce_id      = $urandom;
      cce_mode    = $urandom;
      start_pc    = $urandom;
      ucode_count = cnt;
   endtask

   task automatic push_seq();
      int n;
      n = (ucode_count > 9'd256) ? 256 : int'(ucode_count);
      sb.push_back({16'h0002, 32'd1});
      sb.push_back({16'h0003, core_id});
      sb.push_back({16'h0022, icache_mode});
      sb.push_back({16'h0042, dcache_mode});
      sb.push_back({16'h0060, cce_id});
      sb.push_back({16'h0061, 32'd0});
      sb.push_back({16'h0040, start_pc});
      for (int i = 0; i < n; i++) sb.push_back({16'h8000 + 16'(i), rom[i]});
      sb.push_back({16'h0061, cce_mode});
      sb.push_back({16'h0002, 32'd0});
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 5000 && !seen; c++) begin
         @(negedge clk);
         seen = done;
      end
      check_eq({tag, "_done_in_time"}, 64'(seen), 64'd1);
      check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
      check_eq({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
   endtask

   task automatic run_seq(input string tag, input logic [8:0] cnt, input int exp_reads);
      randomize_inputs(cnt);
      uc_pulses = 0;
      push_seq();
      pulse_start();
      wait_done(tag);
      check_eq({tag, "_uc_reads"}, 64'(uc_pulses), 64'(exp_reads));
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rand_ready = 1'b0;
      cfg_ready = 1'b1;
      start = 1'b0;
      reset_n = 1'b0;
      ucode_data = '0;
      randomize_inputs(9'd0);
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      rom[0] = 32'hA;
      rom[1] = 32'hB;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_cfg_v", 64'(cfg_v), 64'd0);
      check_eq("rst_ucode_v", 64'(ucode_v), 64'd0);
      check_eq("rst_busy_done", 64'({busy, done}), 64'd0);
      check_eq("rst_addr_data", 64'({cfg_addr, cfg_data, ucode_addr}), 64'd0);
      reset_n = 1'b1;

      // Nominal sequence, zero-wait responder.
      run_seq("t1", 9'd2, 2);
      check_eq("t1_done", 64'(done), 64'd1);

      // Backpressure.
      rand_ready = 1'b1;
      run_seq("t2", 9'd5, 5);
      rand_ready = 1'b0;

      // Empty ucode image.
      run_seq("t3", 9'd0, 0);

      // Oversized count clamps to the ROM depth.
      last_uc_addr = '0;
      run_seq("t4", 9'd300, 256);
      check_eq("t4_last_uc_addr", 64'(last_uc_addr), 64'h80FF);

      // Reset during ucode write k=5, then a clean restart.
      randomize_inputs(9'd10);
      push_seq();
      pulse_start();
      begin
         bit hit;
         hit = 1'b0;
         for (int c = 0; c < 2000 && !hit; c++) begin
            @(negedge clk);
            hit = cfg_v && (cfg_addr == 16'h8005);
         end
         check_eq("t5_reach_k5", 64'(hit), 64'd1);
      end
      #2 reset_n = 1'b0;
      #1;
      check_eq("t5_rst_cfg_v", 64'(cfg_v), 64'd0);
      check_eq("t5_rst_busy", 64'(busy), 64'd0);
      check_eq("t5_rst_addr", 64'(cfg_addr), 64'd0);
      sb.delete();
      @(posedge clk);
      #1 reset_n = 1'b1;
      run_seq("t5b", 9'd3, 3);

      // start_i while busy is ignored, and inputs are latched at start acceptance.
      rand_ready = 1'b1;
      randomize_inputs(9'd1);
      uc_pulses = 0;
      push_seq();
      pulse_start();
      randomize_inputs(9'd7);
      pulse_start();
      wait_done("t6");
      check_eq("t6_uc_reads", 64'(uc_pulses), 64'd1);
      rand_ready = 1'b0;

      // Restart from DONE clears done_o and reruns.
      randomize_inputs(9'd2);
      uc_pulses = 0;
      push_seq();
      pulse_start();
      @(negedge clk);
      check_eq("t7_done_cleared", 64'(done), 64'd0);
      check_eq("t7_busy_set", 64'(busy), 64'd1);
      wait_done("t7");
      check_eq("t7_uc_reads", 64'(uc_pulses), 64'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
